// File: rtl/ca_pkg.sv
// ---------------------------------------------------------------------------
// ca_pkg
// Shared types and constants for the cellular-automaton display path.
//   GRID_DIM / GRID_CELLS : geometry of the 8x8 generation grid
//   grid_t                : one full generation, bit row*8+col = cell (row,col)
//   scan_state_t          : row-scanner state encoding
// ---------------------------------------------------------------------------
package ca_pkg;

    localparam int GRID_DIM   = 8;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

    typedef logic [GRID_CELLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/ca_scan_timer.sv
// ---------------------------------------------------------------------------
// ca_scan_timer
// Loadable down-counter used to time both the blanking gap and the row dwell.
// The count stops at zero and waits there until the next load.
//   clk        in  : clock
//   reset      in  : synchronous active-high reset (count -> 0)
//   load       in  : load load_value this cycle (takes priority over counting)
//   load_value in W: value loaded on load
//   done       out : count == 0
// ---------------------------------------------------------------------------
module ca_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/ca_grid_scanner.sv
// ---------------------------------------------------------------------------
// ca_grid_scanner
// Row-multiplexed LED matrix driver for 8x8 automaton generations.
// A snapshot is accepted into a pending buffer and promoted to the display
// buffer only while idle or at a frame boundary, so a frame is never torn.
// Each row is preceded by BLANK_CYCLES of all-off outputs and then driven for
// DWELL_CYCLES cycles.
//   clk        in     : clock
//   reset      in     : synchronous active-high reset
//   grid_in    in  64 : snapshot, bit row*8+col = cell (row,col)
//   grid_valid in     : grid_in valid
//   grid_ready out    : pending buffer empty
//   enable     in     : scanning allowed
//   row_sel    out  8 : one-hot row drive (polarity ROW_ACTIVE_LOW)
//   col_data   out  8 : current row columns (polarity COL_ACTIVE_LOW)
//   row_idx    out  3 : row driven now or next
//   frame_done out    : one-cycle pulse after the row-7 dwell
// ---------------------------------------------------------------------------
module ca_grid_scanner
    import ca_pkg::*;
#(
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  grid_t       grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic [2:0]  row_idx,
    output logic        frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

    // Each row starts in BLANK unless the gap is configured away.
    localparam scan_state_t ROW_ENTRY      = HAS_BLANK ? BLANK : DRIVE;
    localparam logic [CNT_W-1:0] ROW_LOAD  = HAS_BLANK ? BLANK_LOAD : DWELL_LOAD;

    localparam logic [7:0] ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

    scan_state_t       r_state;
    grid_t             r_disp_buf;
    grid_t             r_pend_buf;
    logic              r_pend_full;
    logic [2:0]        r_row_idx;
    logic [7:0]        r_row_sel;
    logic [7:0]        r_col_data;
    logic              r_frame_done;

    scan_state_t       w_state_next;
    logic [2:0]        w_row_idx_next;
    logic              w_swap;
    logic              w_capture;
    logic              w_timer_load;
    logic [CNT_W-1:0]  w_timer_load_value;
    logic              w_timer_done;
    logic              w_frame_done_next;
    logic [7:0]        w_row_sel_next;
    logic [7:0]        w_col_data_next;
    grid_t             w_disp_next;

    ca_scan_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (w_timer_load_value),
        .done       (w_timer_done)
    );

    // Capture and swap are mutually exclusive: one needs an empty pending
    // buffer, the other a full one.
    assign w_capture = grid_valid && !r_pend_full;

    always_comb begin
        w_state_next       = r_state;
        w_row_idx_next     = r_row_idx;
        w_swap             = 1'b0;
        w_timer_load       = 1'b0;
        w_timer_load_value = DWELL_LOAD;
        w_frame_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                w_swap = r_pend_full;
                if (enable) begin
                    w_row_idx_next     = 3'd0;
                    w_state_next       = ROW_ENTRY;
                    w_timer_load       = 1'b1;
                    w_timer_load_value = ROW_LOAD;
                end
            end
            BLANK: begin
                if (!enable) begin
                    w_state_next   = IDLE;
                    w_row_idx_next = 3'd0;
                end else if (w_timer_done) begin
                    w_state_next       = DRIVE;
                    w_timer_load       = 1'b1;
                    w_timer_load_value = DWELL_LOAD;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    // Partial frame is abandoned without a frame_done pulse.
                    w_state_next   = IDLE;
                    w_row_idx_next = 3'd0;
                end else if (w_timer_done) begin
                    if (r_row_idx == 3'd7) begin
                        w_row_idx_next    = 3'd0;
                        w_frame_done_next = 1'b1;
                        w_swap            = r_pend_full;
                    end else begin
                        w_row_idx_next = r_row_idx + 3'd1;
                    end
                    w_state_next       = ROW_ENTRY;
                    w_timer_load       = 1'b1;
                    w_timer_load_value = ROW_LOAD;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_row_idx_next = 3'd0;
            end
        endcase

        // With no blanking gap a swap and the first drive of row 0 share an
        // edge, so the columns must come from the post-swap buffer.
        w_disp_next = w_swap ? r_pend_buf : r_disp_buf;

        w_row_sel_next  = ROW_OFF;
        w_col_data_next = COL_OFF;
        if (w_state_next == DRIVE) begin
            w_row_sel_next  = ROW_OFF ^ (8'h01 << w_row_idx_next);
            w_col_data_next = COL_OFF ^ w_disp_next[{w_row_idx_next, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_disp_buf   <= '0;
            r_pend_buf   <= '0;
            r_pend_full  <= 1'b0;
            r_row_idx    <= 3'd0;
            r_row_sel    <= ROW_OFF;
            r_col_data   <= COL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row_idx    <= w_row_idx_next;
            r_row_sel    <= w_row_sel_next;
            r_col_data   <= w_col_data_next;
            r_frame_done <= w_frame_done_next;
            r_disp_buf   <= w_disp_next;
            if (w_capture) begin
                r_pend_buf  <= grid_in;
                r_pend_full <= 1'b1;
            end else if (w_swap) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign grid_ready = !r_pend_full;
    assign row_sel    = r_row_sel;
    assign col_data   = r_col_data;
    assign row_idx    = r_row_idx;
    assign frame_done = r_frame_done;

endmodule

// File: doc/ca_grid_scanner.md
# ca_grid_scanner

- Downstream display stage of the cellular-automaton core: takes each completed 8x8 generation and drives an 8x8 LED matrix by row multiplexing.
- Accepts a 64-bit grid snapshot over a valid/ready handshake into a pending buffer.
- Promotes the pending buffer to the display buffer only at a frame boundary, so a frame is never torn.
- Scans rows 0..7 with a programmable blanking gap before each row to suppress ghosting.

## Interface

Parameters:
- DWELL_CYCLES, 50000, cycles each row is driven; must be >= 1.
- BLANK_CYCLES, 500, cycles all outputs are inactive before each row; 0 allowed (no BLANK phase).
- ROW_ACTIVE_LOW, 1, 1 = row_sel asserted level is 0.
- COL_ACTIVE_LOW, 0, 1 = col_data lit level is 0.

Ports:
- clk in 1: single clock; reset is synchronous and active-high.
- reset in 1: synchronous, active-high.
- grid_in in 64: snapshot; bit row*8+column is cell (row, column), same indexing as the update stage.
- grid_valid in 1: grid_in is valid.
- grid_ready out 1: pending buffer empty; equals ~pend_full.
- enable in 1: scanning allowed.
- row_sel out 8: per-row drive, one-hot when asserted; polarity set by ROW_ACTIVE_LOW.
- col_data out 8: columns of the current row, bit c = column c; polarity set by COL_ACTIVE_LOW.
- row_idx out 3: row currently driven or about to be driven.
- frame_done out 1: one-cycle pulse at the end of row 7 dwell.

## Operation

- Storage: disp_buf (64 bits), pend_buf (64 bits), pend_full flag.
- Handshake:
  - Capture occurs when grid_valid && grid_ready: pend_buf <= grid_in, pend_full <= 1.
  - grid_in is held/ignored while grid_ready = 0; no overwrite of a full pending buffer.
- States (scan_state_t): IDLE, BLANK, DRIVE.
  - IDLE:
    - Outputs inactive.
    - If pend_full: disp_buf <= pend_buf, pend_full <= 0 (every cycle, with or without enable).
    - If enable: row_idx <= 0, go BLANK (or DRIVE if BLANK_CYCLES = 0).
  - BLANK:
    - Outputs inactive; counter loaded BLANK_CYCLES-1 on entry.
    - On counter 0 go DRIVE.
  - DRIVE:
    - row_sel asserts bit row_idx only; col_data = disp_buf[row_idx*8 +: 8].
    - Counter loaded DWELL_CYCLES-1 on entry; on counter 0:
      - If row_idx < 7: row_idx++.
      - If row_idx = 7: row_idx <= 0, frame_done pulses, and if pend_full then swap pending into display and clear pend_full.
      - Go BLANK (or DRIVE).
- enable low in BLANK/DRIVE: next state IDLE, outputs inactive the following cycle, row_idx <= 0. A partial frame is abandoned and frame_done does not pulse.
- Swap and handshake in the same cycle cannot collide: the handshake requires pend_full = 0, and the swap requires pend_full = 1.
- Counter width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES) + 1).
- row_idx wraps 7 -> 0 only via the frame-end path.

## Timing

- Reset:
  - State IDLE.
  - disp_buf = 0, pend_buf = 0, pend_full = 0, counter = 0, row_idx = 0.
  - grid_ready = 1 in the cycle after reset deasserts.
  - row_sel = inactive (8'hFF if ROW_ACTIVE_LOW, else 0); col_data = inactive (all unlit); frame_done = 0.
- Reset mid-frame returns all registers to the reset values on the next edge and discards pending data.
- All outputs are registered; they reflect the state/row after the edge that enters it.
- Row period is BLANK_CYCLES + DWELL_CYCLES; frame period is 8 x that.
- From enable rising in IDLE (edge E):
  - BLANK spans edges E+1 .. E+BLANK_CYCLES.
  - Row 0 drives for exactly DWELL_CYCLES cycles.
- frame_done is high in the cycle right after the last row-7 drive cycle, coinciding with the first BLANK cycle.
- A grid accepted at any point of frame N is first displayed in frame N+1. In IDLE it is displayed from the cycle after capture+1.
- grid_ready rises the cycle after the swap.

## Structure

- ca_pkg holds:
  - GRID_DIM = 8, GRID_CELLS = 64.
  - typedef logic [GRID_CELLS-1:0] grid_t.
  - typedef enum scan_state_t {IDLE, BLANK, DRIVE}.
- Sub-module ca_scan_timer: loadable down-counter with load, load_value, and done (count == 0). It is instantiated once and shared by BLANK and DRIVE.
- The FSM, buffers and output registers stay in ca_grid_scanner.

## Test plan

Run with DWELL_CYCLES = 4, BLANK_CYCLES = 2, ROW_ACTIVE_LOW = 1, COL_ACTIVE_LOW = 0.

- Reset, hold enable = 0:
  - row_sel = 8'hFF, col_data = 0, grid_ready = 1.
  - Load 64'h8000_0000_0000_0001 in IDLE: pend_full clears after 1 cycle.
- Enable with grid 64'h8000_0000_0000_0001:
  - Row 0 shows col_data 8'h01, row_sel 8'hFE for 4 cycles; rows 1-6 show 0; row 7 shows 8'h80, row_sel 8'h7F.
  - 2 inactive cycles precede each row; frame_done pulses every 48 cycles.
- Mid-frame load of 64'hFFFF_FFFF_FFFF_FFFF during row 3:
  - Current frame still shows the old grid.
  - grid_ready stays 0 until the frame end; the next frame shows all 8'hFF.
  - A second grid_valid while full is not accepted.
- Drop enable during row 5 drive:
  - Outputs inactive next cycle, no frame_done.
  - Re-enable: the scan restarts at row 0 after 2 blank cycles.
- Assert reset during a DRIVE cycle of row 6 with pend_full = 1:
  - Next cycle: all outputs inactive, grid_ready = 1.
  - After re-enable, disp_buf = 0, so every row shows col_data 0.
- Parameter BLANK_CYCLES = 0: rows are contiguous, the frame is 32 cycles, and row_sel is never all-inactive while enabled.
